async_fifo_wr_ctrl: RTL and testbench
=====================================

Name: async_fifo_wr_ctrl

Overview:
Parametrised write-side controller for the dual-clock FIFO; the next generation of the write-pointer/full-flag logic. It keeps the write pointer in binary and Gray form and synchronises the read-domain Gray pointer internally with a configurable number of flops. It generates registered full and almost-full flags, the write fill level, and a sticky overflow flag. It sits in the write clock domain, between the write client and the dual-port RAM write port.

Parameters:
ADDR_W, 4, address width; FIFO depth = 2^ADDR_W; legal range 2..12.
SYNC_STAGES, 2, flops in the read-pointer synchroniser; legal range 2..4.
AF_RESET, 2^ADDR_W-2, reset value of the internal almost-full threshold when `af_thresh_ld` is never used.

Ports:
w_clk  in  1  write-domain clock.
w_rst_n  in  1  asynchronous active-low reset.
w_en  in  1  write request from client.
read_addr_gray  in  ADDR_W+1  read pointer in Gray code, launched from the read domain (asynchronous).
af_thresh  in  ADDR_W+1  almost-full threshold value.
af_thresh_ld  in  1  loads `af_thresh` into the internal threshold register.
ovf_clr  in  1  clears the sticky overflow flag.
write_addr  out  ADDR_W  RAM write address (binary pointer without its MSB).
write_addr_gray  out  ADDR_W+1  registered Gray write pointer, sent to the read domain.
write_accept  out  1  combinational: w_en && !flag_full; the RAM write enable.
flag_full  out  1  registered full flag.
flag_almost_full  out  1  registered; asserted when level >= threshold.
flag_overflow  out  1  sticky; a write was attempted while full.
write_level  out  ADDR_W+1  registered fill level as seen by the write domain, range 0..2^ADDR_W.

Behaviour:
- Decided: one clock (`w_clk`); reset `w_rst_n` is asynchronous and active-low.
- Reset (async, w_rst_n=0): all outputs listed below are 0.
  - binary pointer wbin, `write_addr`, `write_addr_gray`
  - every synchroniser stage, `write_level`
  - `flag_full`, `flag_almost_full`, `flag_overflow`
  - The threshold register resets to AF_RESET.
- Reset deassertion needs no internal synchroniser; the system provides a synchronously released reset.
- Synchroniser: `read_addr_gray` passes through SYNC_STAGES flops → rgray_s. It is converted Gray→binary combinationally → rbin_s.
- Write acceptance: `write_accept` = w_en & !flag_full.
  - wbin_next = wbin + write_accept, modulo 2^(ADDR_W+1); the pointer wraps naturally, no special case.
- Registered state, updated every w_clk edge:
  - wbin <= wbin_next.
  - `write_addr_gray` <= (wbin_next>>1) ^ wbin_next.
  - `flag_full` <= (gray(wbin_next) == {~rgray_s[ADDR_W:ADDR_W-1], rgray_s[ADDR_W-2:0]}).
  - `write_level` <= wbin_next - rbin_s, modulo 2^(ADDR_W+1).
  - `flag_almost_full` <= (wbin_next - rbin_s) >= thresh.
- Timing of full: `flag_full` is 1 in the cycle immediately after the write that fills the last entry. There is no extra lag.
- Timing of deassertion: release of full/almost-full after the read side advances lags by SYNC_STAGES+1 w_clk cycles, which is pessimistic and safe.
- `write_addr` = wbin[ADDR_W-1:0].
- Overflow: w_en & flag_full sets `flag_overflow` on the next edge. `ovf_clr` clears it.
  - If set and clear occur in the same cycle, set wins.
  - The pointer never moves while full.
- Threshold:
  - af_thresh_ld=1 loads `af_thresh` at the edge.
  - Values > 2^ADDR_W saturate to 2^ADDR_W.
  - A threshold of 0 forces almost-full to 1 from the next edge.
  - A threshold change takes effect on flags one edge after the load.
- Writes while full are dropped; the RAM is not written because write_accept=0.
- Reset mid-operation:
  - All state clears immediately, asynchronously.
  - A w_en held through reset release is accepted on the first edge after release.

Test Plan:
- Reset, ADDR_W=4, read_addr_gray=0 → all outputs 0; `flag_almost_full`=0 with threshold 14.
- 16 consecutive writes, read pointer held at 0:
  - `write_addr` steps 0..15 then back to 0.
  - `write_level` reaches 16; `flag_full`=1 the cycle after the 16th write.
  - `flag_almost_full`=1 from level 14.
- While full, assert w_en for 3 cycles:
  - `write_accept`=0 and pointer unchanged.
  - `flag_overflow`=1 and stays set.
  - `ovf_clr` together with w_en → still 1; `ovf_clr` alone → 0.
- From full, drive read_addr_gray=gray(4) → full and almost-full both drop exactly SYNC_STAGES+1 cycles later, with `write_level`=12.
- Wrap: cycle 40 writes with the read pointer trailing by 3 → `write_addr_gray` always changes by exactly 1 bit per accepted write; wbin MSB toggles at 16 and 32; level stays 3.
- Load af_thresh=20 → threshold saturates to 16; assert w_rst_n=0 mid-burst → all outputs 0 asynchronously, before the next w_clk edge.

Source files
------------

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller for the dual-clock FIFO: binary/Gray write pointer,
// read-pointer synchroniser, full/almost-full/overflow flags and fill level.
module async_fifo_wr_ctrl #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_RESET    = (1 << ADDR_W) - 2
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_en,
  input  logic [ADDR_W:0]   read_addr_gray,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic              af_thresh_ld,
  input  logic              ovf_clr,
  output logic [ADDR_W-1:0] write_addr,
  output logic [ADDR_W:0]   write_addr_gray,
  output logic              write_accept,
  output logic              flag_full,
  output logic              flag_almost_full,
  output logic              flag_overflow,
  output logic [ADDR_W:0]   write_level
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] rgray_s;
  logic [PTR_W-1:0] rbin_s;
  logic [PTR_W-1:0] full_cmp;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] thresh;
  logic [PTR_W-1:0] sync_q [SYNC_STAGES];

  assign write_accept = w_en & ~flag_full;
  assign wbin_next    = wbin + PTR_W'(write_accept);
  assign wgray_next   = (wbin_next >> 1) ^ wbin_next;
  assign rgray_s      = sync_q[SYNC_STAGES-1];
  assign write_addr   = wbin[ADDR_W-1:0];

  // Full when the write Gray pointer equals the read Gray pointer one lap ahead
  assign full_cmp   = {~rgray_s[ADDR_W:ADDR_W-1], rgray_s[ADDR_W-2:0]};
  assign level_next = wbin_next - rbin_s;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i < int'(PTR_W); i++) begin
      rbin_s[i] = ^(rgray_s >> i);
    end
  end

  // Read-pointer synchroniser chain
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= read_addr_gray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Almost-full threshold, saturated to the FIFO depth on load
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      thresh <= PTR_W'(AF_RESET);
    end else if (af_thresh_ld) begin
      thresh <= (af_thresh > PTR_W'(DEPTH)) ? PTR_W'(DEPTH) : af_thresh;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wbin             <= '0;
      write_addr_gray  <= '0;
      flag_full        <= 1'b0;
      write_level      <= '0;
      flag_almost_full <= 1'b0;
      flag_overflow    <= 1'b0;
    end else begin
      wbin             <= wbin_next;
      write_addr_gray  <= wgray_next;
      flag_full        <= (wgray_next == full_cmp);
      write_level      <= level_next;
      flag_almost_full <= (level_next >= thresh);
      // A new overflow in the same cycle as a clear keeps the flag set
      flag_overflow    <= (w_en & flag_full) | (flag_overflow & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Self-checking bench for async_fifo_wr_ctrl: occupancy-count model plus
// directed fill, overflow, release, wrap, threshold and async-reset scenarios.
module tb_async_fifo_wr_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned S     = 2;
  localparam int unsigned PW    = AW + 1;
  localparam int          DEPTH = 16;
  localparam int          MOD   = 32;

  logic          w_clk = 1'b0;
  logic          w_rst_n = 1'b0;
  logic          w_en = 1'b0;
  logic [PW-1:0] read_addr_gray = '0;
  logic [PW-1:0] af_thresh = '0;
  logic          af_thresh_ld = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [AW-1:0] write_addr;
  logic [PW-1:0] write_addr_gray;
  logic          write_accept;
  logic          flag_full;
  logic          flag_almost_full;
  logic          flag_overflow;
  logic [PW-1:0] write_level;

  async_fifo_wr_ctrl #(.ADDR_W(AW), .SYNC_STAGES(S)) dut (
    .w_clk            (w_clk),
    .w_rst_n          (w_rst_n),
    .w_en             (w_en),
    .read_addr_gray   (read_addr_gray),
    .af_thresh        (af_thresh),
    .af_thresh_ld     (af_thresh_ld),
    .ovf_clr          (ovf_clr),
    .write_addr       (write_addr),
    .write_addr_gray  (write_addr_gray),
    .write_accept     (write_accept),
    .flag_full        (flag_full),
    .flag_almost_full (flag_almost_full),
    .flag_overflow    (flag_overflow),
    .write_level      (write_level)
  );

  always #5 w_clk = ~w_clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  int rd_bin = 0;

  // Model state: write count mod 2*DEPTH, visible occupancy, flags
  int m_w, m_lvl, m_th;
  bit m_full, m_af, m_ovf;
  int sq[$];

  function automatic logic [PW-1:0] gray(input int v);
    logic [PW-1:0] b;
    b = PW'(v % MOD);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge w_clk);
    #1;
  endtask

  task automatic set_rd(input int v);
    rd_bin = v;
    read_addr_gray = gray(v);
  endtask

  // The write domain sees the read pointer sampled S edges earlier
  always @(posedge w_clk or negedge w_rst_n) begin
    int seen;
    bit acc, ovf_n;
    if (!w_rst_n) begin
      m_w = 0; m_lvl = 0; m_th = DEPTH - 2;
      m_full = 0; m_af = 0; m_ovf = 0;
      sq.delete();
      repeat (S) sq.push_back(0);
    end else begin
      acc   = w_en && !m_full;
      ovf_n = (w_en && m_full) || (m_ovf && !ovf_clr);
      seen  = sq.pop_front();
      sq.push_back(rd_bin % MOD);
      m_w    = (m_w + int'(acc)) % MOD;
      m_lvl  = (m_w - seen + MOD) % MOD;
      m_full = (m_lvl == DEPTH);
      m_af   = (m_lvl >= m_th);
      m_ovf  = ovf_n;
      if (af_thresh_ld) m_th = (int'(af_thresh) > DEPTH) ? DEPTH : int'(af_thresh);
    end
  end

  always @(negedge w_clk) begin
    if (w_rst_n && chk_en) begin
      check("m_addr",   int'(write_addr),       m_w % DEPTH);
      check("m_gray",   int'(write_addr_gray),  int'(gray(m_w)));
      check("m_full",   int'(flag_full),        int'(m_full));
      check("m_af",     int'(flag_almost_full), int'(m_af));
      check("m_ovf",    int'(flag_overflow),    int'(m_ovf));
      check("m_level",  int'(write_level),      m_lvl);
      check("m_accept", int'(write_accept),     int'(w_en && !m_full));
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_addr"},  int'(write_addr),       0);
    check({tag, "_gray"},  int'(write_addr_gray),  0);
    check({tag, "_full"},  int'(flag_full),        0);
    check({tag, "_af"},    int'(flag_almost_full), 0);
    check({tag, "_ovf"},   int'(flag_overflow),    0);
    check({tag, "_level"}, int'(write_level),      0);
  endtask

  task automatic do_reset();
    w_rst_n = 1'b0;
    w_en = 1'b0;
    set_rd(0);
    cyc();
    w_rst_n = 1'b1;
  endtask

  logic [PW-1:0] prev_gray;

  initial begin
    set_rd(0);
    repeat (2) cyc();
    check_zero("rst");
    w_rst_n = 1'b1;
    chk_en  = 1'b1;
    cyc();
    check_zero("idle");

    // Fill all 16 entries with the read pointer parked at 0
    w_en = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      cyc();
      if (i == 13) check("af_lvl13", int'(flag_almost_full), 0);
      if (i == 14) check("af_lvl14", int'(flag_almost_full), 1);
      if (i == 15) check("addr_15", int'(write_addr), 15);
    end
    check("full_16",  int'(flag_full),   1);
    check("level_16", int'(write_level), 16);
    check("addr_wrap", int'(write_addr), 0);

    // Writes while full are dropped and set the sticky overflow
    repeat (3) cyc();
    check("ovf_set",    int'(flag_overflow), 1);
    check("ovf_accept", int'(write_accept),  0);
    check("ovf_addr",   int'(write_addr),    0);
    ovf_clr = 1'b1;
    cyc();
    check("ovf_set_wins", int'(flag_overflow), 1);
    w_en = 1'b0;
    cyc();
    check("ovf_cleared", int'(flag_overflow), 0);
    ovf_clr = 1'b0;

    // Read side advances by 4: flags release S+1 edges later
    set_rd(4);
    repeat (S) cyc();
    check("rel_still_full", int'(flag_full), 1);
    cyc();
    check("rel_full",  int'(flag_full),        0);
    check("rel_af",    int'(flag_almost_full), 0);
    check("rel_level", int'(write_level),      12);

    // Threshold 20 saturates to 16
    do_reset();
    af_thresh = PW'(20);
    af_thresh_ld = 1'b1;
    cyc();
    af_thresh_ld = 1'b0;
    w_en = 1'b1;
    repeat (15) cyc();
    check("sat_af15", int'(flag_almost_full), 0);
    cyc();
    check("sat_af16", int'(flag_almost_full), 1);
    check("sat_full", int'(flag_full), 1);

    // 40 writes with the visible read pointer trailing by 3
    do_reset();
    w_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_rd((i + int'(S) - 2 < 0) ? 0 : i + int'(S) - 2);
      prev_gray = write_addr_gray;
      cyc();
      check("gray_1bit", $countones(prev_gray ^ write_addr_gray), 1);
    end
    check("wrap_level", int'(write_level), 3);
    check("wrap_addr",  int'(write_addr),  8);

    // Asynchronous reset mid-burst, w_en held through release
    #3;
    w_rst_n = 1'b0;
    #1;
    check_zero("async");
    set_rd(0);
    repeat (2) cyc();
    w_rst_n = 1'b1;
    cyc();
    check("post_rst_addr",  int'(write_addr),  1);
    check("post_rst_level", int'(write_level), 1);

    // Threshold 0 forces almost-full one edge after the load
    w_en = 1'b0;
    af_thresh = '0;
    af_thresh_ld = 1'b1;
    cyc();
    af_thresh_ld = 1'b0;
    check("th0_load_edge", int'(flag_almost_full), 0);
    cyc();
    check("th0_af", int'(flag_almost_full), 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
